// File: rtl/pc_sequencer.sv
// Program-counter sequencer: advances the fetch address every wait_cycle+1 cycles,
// with branch redirect, stall, halt/resume and a one-cycle commit strobe.
module pc_sequencer #(
    parameter int unsigned          ADDR_WIDTH   = 16,
    parameter int unsigned          WAIT_WIDTH   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int unsigned          INC_STEP     = 1
) (
    input  logic                  clk0,
    input  logic                  reset,
    input  logic [WAIT_WIDTH-1:0] wait_cycle,
    input  logic                  stall,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [ADDR_WIDTH-1:0] address_out,
    output logic                  commit,
    output logic                  branch_pending,
    output logic                  halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [WAIT_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] target_q, target_d;
    logic                  commit_d;
    logic                  pending_d;
    logic                  halt_pend_q, halt_pend_d;
    logic                  halted_d;

    // State and output registers
    always_ff @(posedge clk0) begin
        if (reset) begin
            state_q        <= ST_RUN;
            count_q        <= '0;
            address_out    <= RESET_VECTOR;
            target_q       <= '0;
            commit         <= 1'b0;
            branch_pending <= 1'b0;
            halt_pend_q    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            address_out    <= addr_d;
            target_q       <= target_d;
            commit         <= commit_d;
            branch_pending <= pending_d;
            halt_pend_q    <= halt_pend_d;
            halted         <= halted_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = address_out;
        target_d    = target_q;
        commit_d    = 1'b0;
        pending_d   = branch_pending;
        halt_pend_d = halt_pend_q;
        halted_d    = halted;

        // Branch requests are captured in every state; last one wins.
        if (branch_valid) begin
            target_d  = branch_target;
            pending_d = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    if (halt_req) halt_pend_d = 1'b1;
                end else if (count_q < wait_cycle) begin
                    count_d = WAIT_WIDTH'(count_q + 1'b1);
                    if (halt_req) halt_pend_d = 1'b1;
                end else begin
                    // Commit point; >= lets a shrunken wait_cycle end the count at once.
                    count_d = '0;
                    if (halt_pend_q || halt_req) begin
                        state_d     = ST_HALTED;
                        halted_d    = 1'b1;
                        halt_pend_d = 1'b0;
                    end else begin
                        if (branch_valid)
                            addr_d = branch_target;
                        else if (branch_pending)
                            addr_d = target_q;
                        else
                            addr_d = ADDR_WIDTH'(address_out + ADDR_WIDTH'(INC_STEP));
                        commit_d  = 1'b1;
                        pending_d = 1'b0;
                    end
                end
            end
            ST_HALTED: begin
                count_d = '0;
                if (resume) begin
                    state_d  = ST_RUN;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_RUN;
                halted_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed literal cases followed by
// randomized traffic compared cycle-by-cycle against a behavioural model.
module tb_pc_sequencer;

    localparam int unsigned AW = 16;
    localparam int unsigned WW = 2;
    localparam int unsigned RV = 0;
    localparam int unsigned STEP = 1;

    logic          clk0 = 1'b0;
    logic          reset;
    logic [WW-1:0] wait_cycle;
    logic          stall;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic          resume;
    logic [AW-1:0] address_out;
    logic          commit;
    logic          branch_pending;
    logic          halted;

    int n_total = 0;
    int n_pass  = 0;

    // Behavioural model: plain integers describing the program-counter's observable state
    int m_addr, m_wait_done, m_tgt;
    bit m_commit, m_pend, m_halt_pend, m_halted;

    pc_sequencer #(
        .ADDR_WIDTH  (AW),
        .WAIT_WIDTH  (WW),
        .RESET_VECTOR(AW'(RV)),
        .INC_STEP    (STEP)
    ) dut (
        .clk0          (clk0),
        .reset         (reset),
        .wait_cycle    (wait_cycle),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .address_out   (address_out),
        .commit        (commit),
        .branch_pending(branch_pending),
        .halted        (halted)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // One clock: advance the model with the inputs presently driven, then compare.
    task automatic cycle();
        int  elapsed;
        bit  at_commit;
        elapsed = m_wait_done;
        m_commit = 1'b0;
        if (reset) begin
            m_addr = RV; m_wait_done = 0; m_pend = 0; m_halt_pend = 0; m_halted = 0; m_tgt = 0;
        end else begin
            at_commit = !m_halted && !stall && (elapsed >= int'(wait_cycle));
            if (m_halted) begin
                m_wait_done = 0;
                if (resume) m_halted = 0;
            end else if (!at_commit) begin
                if (!stall) m_wait_done = elapsed + 1;
                if (halt_req) m_halt_pend = 1;
            end else begin
                m_wait_done = 0;
                if (m_halt_pend || halt_req) begin
                    m_halted = 1; m_halt_pend = 0;
                end else begin
                    if (branch_valid)  m_addr = int'(branch_target);
                    else if (m_pend)   m_addr = m_tgt;
                    else               m_addr = (m_addr + STEP) % (1 << AW);
                    m_commit = 1;
                    m_pend = 0;
                end
            end
            if (branch_valid && !(at_commit && m_commit)) begin
                m_pend = 1; m_tgt = int'(branch_target);
            end
        end
        @(posedge clk0);
        #1;
        chk("address_out", int'(address_out), m_addr);
        chk("commit", int'(commit), int'(m_commit));
        chk("branch_pending", int'(branch_pending), int'(m_pend));
        chk("halted", int'(halted), int'(m_halted));
    endtask

    task automatic idle_inputs();
        stall = 0; branch_valid = 0; branch_target = '0; halt_req = 0; resume = 0;
    endtask

    task automatic do_reset(input int w);
        reset = 1; wait_cycle = WW'(w); idle_inputs();
        cycle();
        reset = 0;
    endtask

    initial begin
        reset = 1; wait_cycle = '0; idle_inputs();
        m_addr = 0; m_wait_done = 0; m_tgt = 0;
        m_commit = 0; m_pend = 0; m_halt_pend = 0; m_halted = 0;

        // Reset state
        do_reset(0);
        chk("rst_addr", int'(address_out), RV);
        chk("rst_commit", int'(commit), 0);
        chk("rst_pending", int'(branch_pending), 0);
        chk("rst_halted", int'(halted), 0);

        // wait_cycle=0: advances every cycle, commit held high
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("w0_addr", int'(address_out), i);
            chk("w0_commit", int'(commit), 1);
        end

        // wait_cycle=3: first change after the 4th edge
        do_reset(3);
        for (int i = 1; i <= 3; i++) begin
            cycle();
            chk("w3_hold", int'(address_out), 0);
        end
        cycle();
        chk("w3_addr1", int'(address_out), 1);
        chk("w3_commit", int'(commit), 1);

        // Branch at counter=1 with wait_cycle=3
        cycle();
        chk("w3_commit_drop", int'(commit), 0);
        branch_valid = 1; branch_target = 16'h0040;
        cycle();
        idle_inputs();
        chk("br_pend1", int'(branch_pending), 1);
        cycle();
        chk("br_pend2", int'(branch_pending), 1);
        cycle();
        chk("br_addr", int'(address_out), 'h40);
        chk("br_pend_clr", int'(branch_pending), 0);

        // Wrap at 0xFFFF
        do_reset(0);
        branch_valid = 1; branch_target = 16'hFFFF;
        cycle();
        idle_inputs();
        chk("wrap_ffff", int'(address_out), 'hFFFF);
        cycle();
        chk("wrap_zero", int'(address_out), 0);

        // Halt at 0x0005 then resume
        do_reset(0);
        branch_valid = 1; branch_target = 16'h0005;
        cycle();
        idle_inputs();
        wait_cycle = 2'd1; halt_req = 1;
        cycle();
        halt_req = 0;
        cycle();
        chk("halt_flag", int'(halted), 1);
        chk("halt_addr", int'(address_out), 5);
        cycle(); cycle();
        chk("halt_hold", int'(address_out), 5);
        resume = 1;
        cycle();
        resume = 0;
        chk("resume_flag", int'(halted), 0);
        cycle();
        chk("resume_wait", int'(address_out), 5);
        cycle();
        chk("resume_addr", int'(address_out), 6);
        chk("resume_commit", int'(commit), 1);

        // Reset mid-count with a pending branch
        do_reset(3);
        cycle();
        branch_valid = 1; branch_target = 16'h1234;
        cycle();
        idle_inputs();
        chk("pre_rst_pend", int'(branch_pending), 1);
        reset = 1;
        cycle();
        reset = 0;
        chk("rst2_addr", int'(address_out), RV);
        chk("rst2_pend", int'(branch_pending), 0);
        chk("rst2_commit", int'(commit), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(49) == 0) wait_cycle = WW'($urandom);
            reset         = ($urandom_range(299) == 0);
            stall         = ($urandom_range(5) == 0);
            branch_valid  = ($urandom_range(9) == 0);
            branch_target = AW'($urandom);
            halt_req      = ($urandom_range(39) == 0);
            resume        = ($urandom_range(7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
